data_mem_io: RTL and testbench

Data-memory stage of the single-cycle CPU. It consumes the core's memory-side outputs (`mem_read`, `mem_write`, ALU result as address, register-file port-2 value as store data) and returns `read_data` to the core's `data_mem_out` input in the same cycle. It holds a word-addressed data RAM plus a small memory-mapped I/O region:
- LED register
- free-running cycle counter
- byte-transmit FIFO with a valid/ready handshake toward a serial transmitter

---
 rtl/data_mem_io_pkg.sv | 36 +++
 rtl/data_mem_io_tx_fifo.sv | 59 +++++
 rtl/data_mem_io.sv | 114 +++++++++++
 tb/tb_data_mem_io.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_io_pkg.sv
// Shared constants for the data-memory stage: MMIO address map and STATUS bit layout.
// Also holds the MMIO decode helper shared by the top level.
package data_mem_io_pkg;

    localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;
    localparam logic [3:0]  OFF_LED    = 4'h0;
    localparam logic [3:0]  OFF_CYCLE  = 4'h4;
    localparam logic [3:0]  OFF_TXDATA = 4'h8;
    localparam logic [3:0]  OFF_STATUS = 4'hC;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_LED,
        SEL_CYCLE,
        SEL_TXDATA,
        SEL_STATUS
    } sel_e;

    // Takes the word address only, so byte-lane bits never influence the decode.
    function automatic sel_e mmio_sel(input logic [29:0] waddr);
        sel_e s;
        s = SEL_NONE;
        if ({waddr, 2'b00} == (MMIO_BASE | {28'b0, OFF_LED}))    s = SEL_LED;
        if ({waddr, 2'b00} == (MMIO_BASE | {28'b0, OFF_CYCLE}))  s = SEL_CYCLE;
        if ({waddr, 2'b00} == (MMIO_BASE | {28'b0, OFF_TXDATA})) s = SEL_TXDATA;
        if ({waddr, 2'b00} == (MMIO_BASE | {28'b0, OFF_STATUS})) s = SEL_STATUS;
        return s;
    endfunction

endpackage

// File: rtl/data_mem_io_tx_fifo.sv
// Byte FIFO feeding the serial transmitter; head is presented with a valid/ready handshake.
// A push into a full FIFO is accepted only if the head is popped in the same cycle.
module tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     ready,
    output logic [7:0]               data,
    output logic                     valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   cnt;
    logic          pop;
    logic          accept;

    assign full   = (cnt == (PW+1)'(DEPTH));
    assign empty  = (cnt == '0);
    assign pop    = !empty && ready;
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    // Gate the head with empty so the output is clean after reset despite unreset storage.
    assign data  = empty ? 8'h00 : mem[rd_ptr];
    assign valid = !empty;
    assign count = cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/data_mem_io.sv
// Data-memory stage of the single-cycle core: word RAM plus LED, cycle counter and TX FIFO MMIO.
// Loads are combinational; every state change lands on the rising clock edge.
module data_mem_io
    import data_mem_io_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int FIFO_DEPTH = 4,
    parameter int LED_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       addr,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic [LED_W-1:0]  led,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram [DEPTH];
    logic [31:0]   cycle_cnt;
    logic          overflow;
    logic [AW-1:0] ram_idx;
    logic          ram_hit;
    sel_e          sel;
    logic [31:0]   status_word;

    logic          fifo_push;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_drop;
    logic [CW-1:0] fifo_count;

    logic          unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    assign ram_idx = addr[AW+1:2];
    assign ram_hit = (addr[31:AW+2] == '0);

    always_comb begin
        sel = SEL_NONE;
        if (ram_hit) sel = SEL_RAM;
        else         sel = mmio_sel(addr[31:2]);
    end

    always_comb begin
        status_word                     = 32'h0;
        status_word[ST_FULL]            = fifo_full;
        status_word[ST_EMPTY]           = fifo_empty;
        status_word[ST_OVF]             = overflow;
        status_word[ST_CNT_LSB +: 8]    = 8'(fifo_count);
    end

    always_comb begin
        read_data = 32'h0;
        if (mem_read) begin
            case (sel)
                SEL_RAM:    read_data = ram[ram_idx];
                SEL_LED:    read_data = 32'(led);
                SEL_CYCLE:  read_data = cycle_cnt;
                SEL_STATUS: read_data = status_word;
                default:    read_data = 32'h0;
            endcase
        end
    end

    assign fifo_push = mem_write && (sel == SEL_TXDATA);

    always_ff @(posedge clk) begin
        if (mem_write && sel == SEL_RAM) ram[ram_idx] <= write_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led       <= '0;
            cycle_cnt <= 32'h0;
            overflow  <= 1'b0;
        end else begin
            if (mem_write && sel == SEL_LED) led <= write_data[LED_W-1:0];

            if (mem_write && sel == SEL_CYCLE) cycle_cnt <= 32'h0;
            else                               cycle_cnt <= cycle_cnt + 32'd1;

            // A fresh drop outranks a software clear in the same cycle.
            if (fifo_drop)
                overflow <= 1'b1;
            else if (mem_write && sel == SEL_STATUS && write_data[ST_OVF])
                overflow <= 1'b0;
        end
    end

    tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (write_data[7:0]),
        .ready     (tx_ready),
        .data      (tx_data),
        .valid     (tx_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .drop      (fifo_drop)
    );

endmodule

// File: tb/tb_data_mem_io.sv
// Directed self-checking bench for data_mem_io: RAM, LED, cycle counter, TX FIFO and async reset.
module tb_data_mem_io;

    localparam logic [31:0] A_LED    = 32'hFFFF_0000;
    localparam logic [31:0] A_CYCLE  = 32'hFFFF_0004;
    localparam logic [31:0] A_TXDATA = 32'hFFFF_0008;
    localparam logic [31:0] A_STATUS = 32'hFFFF_000C;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [15:0] led;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int tests_run;
    int tests_failed;

    data_mem_io #(
        .DEPTH      (256),
        .FIFO_DEPTH (4),
        .LED_W      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .led        (led),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts at a negedge, commits at the following posedge, returns at the next negedge.
    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        mem_write  = 1'b1;
        addr       = a;
        write_data = d;
        @(negedge clk);
        mem_write  = 1'b0;
    endtask

    task automatic read_word(input logic [31:0] a, output logic [31:0] d);
        mem_read = 1'b1;
        addr     = a;
        #1;
        d        = read_data;
        mem_read = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        tests_run++;
        if (led !== 16'h0) begin tests_failed++; $display("FAIL reset_led got %h exp %h", led, 16'h0); end
        tests_run++;
        if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
        tests_run++;
        if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
        tests_run++;
        if (read_data !== 32'h0) begin tests_failed++; $display("FAIL reset_read_data got %h exp 0", read_data); end
        read_word(A_STATUS, d);
        tests_run++;
        if (d !== 32'h0000_0002) begin tests_failed++; $display("FAIL reset_status got %h exp 00000002", d); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_ram();
        logic [31:0] d;
        write_word(32'h0000_0014, 32'h1234_5678);
        write_word(32'h0000_0010, 32'hDEAD_BEEF);
        read_word(32'h0000_0010, d);
        tests_run++;
        if (d !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL ram_rd_10 got %h exp deadbeef", d); end
        read_word(32'h0000_0011, d);
        tests_run++;
        if (d !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL ram_rd_11 got %h exp deadbeef", d); end
        read_word(32'h0000_0013, d);
        tests_run++;
        if (d !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL ram_rd_13 got %h exp deadbeef", d); end
        read_word(32'h0000_0014, d);
        tests_run++;
        if (d !== 32'h1234_5678) begin tests_failed++; $display("FAIL ram_rd_14 got %h exp 12345678", d); end
        addr = 32'h0000_0010;
        #1;
        tests_run++;
        if (read_data !== 32'h0) begin tests_failed++; $display("FAIL ram_no_read got %h exp 0", read_data); end
        @(negedge clk);
        // Simultaneous load and store: load sees the old word.
        mem_read   = 1'b1;
        mem_write  = 1'b1;
        addr       = 32'h0000_0010;
        write_data = 32'hCAFE_F00D;
        #1;
        tests_run++;
        if (read_data !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL ram_rw_old got %h exp deadbeef", read_data); end
        @(negedge clk);
        mem_write = 1'b0;
        mem_read  = 1'b0;
        read_word(32'h0000_0010, d);
        tests_run++;
        if (d !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL ram_rw_new got %h exp cafef00d", d); end
        @(negedge clk);
        write_word(32'h0000_0000, 32'h1111_1111);
        write_word(32'h0000_03FC, 32'h2222_2222);
        write_word(32'h0000_0400, 32'h0BAD_0BAD);
        read_word(32'h0000_0400, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL ram_above_depth got %h exp 0", d); end
        read_word(32'h0000_0000, d);
        tests_run++;
        if (d !== 32'h1111_1111) begin tests_failed++; $display("FAIL ram_no_alias got %h exp 11111111", d); end
        read_word(32'h0000_03FC, d);
        tests_run++;
        if (d !== 32'h2222_2222) begin tests_failed++; $display("FAIL ram_top_word got %h exp 22222222", d); end
        @(negedge clk);
    endtask

    task automatic test_led();
        logic [31:0] d;
        write_word(A_LED, 32'h0001_2345);
        tests_run++;
        if (led !== 16'h2345) begin tests_failed++; $display("FAIL led_out got %h exp 2345", led); end
        read_word(A_LED, d);
        tests_run++;
        if (d !== 32'h0000_2345) begin tests_failed++; $display("FAIL led_readback got %h exp 00002345", d); end
        read_word(32'hFFFF_0020, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL unmapped_read got %h exp 0", d); end
        @(negedge clk);
    endtask

    task automatic test_cycle();
        logic [31:0] d;
        write_word(A_CYCLE, 32'h0000_0123);
        for (int i = 0; i < 3; i++) begin
            read_word(A_CYCLE, d);
            tests_run++;
            if (d !== 32'(i)) begin tests_failed++; $display("FAIL cycle_seq_%0d got %h exp %h", i, d, 32'(i)); end
            @(negedge clk);
        end
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        read_word(A_CYCLE, d);
        tests_run++;
        if (d !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL cycle_max got %h exp ffffffff", d); end
        @(negedge clk);
        read_word(A_CYCLE, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL cycle_wrap got %h exp 0", d); end
        @(negedge clk);
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] d;
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) write_word(A_TXDATA, 32'h0000_0041 + 32'(i));
        read_word(A_STATUS, d);
        tests_run++;
        if (d !== 32'h0000_0405) begin tests_failed++; $display("FAIL fifo_status_ovf got %h exp 00000405", d); end
        read_word(A_TXDATA, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL txdata_read got %h exp 0", d); end
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h41 + 8'(i)) begin
                tests_failed++;
                $display("FAIL fifo_drain_%0d got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, 8'h41 + 8'(i));
            end
            @(negedge clk);
        end
        #1;
        tests_run++;
        if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL fifo_drained_valid got %b exp 0", tx_valid); end
        tx_ready = 1'b0;
        @(negedge clk);
        write_word(A_STATUS, 32'h0000_0004);
        read_word(A_STATUS, d);
        tests_run++;
        if (d !== 32'h0000_0002) begin tests_failed++; $display("FAIL fifo_ovf_clear got %h exp 00000002", d); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) write_word(A_TXDATA, 32'h0000_0051 + 32'(i));
        tx_ready = 1'b1;
        write_word(A_TXDATA, 32'h0000_0055);
        tx_ready = 1'b0;
        read_word(A_STATUS, d);
        tests_run++;
        if (d !== 32'h0000_0401) begin tests_failed++; $display("FAIL b2b_status got %h exp 00000401", d); end
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h52 + 8'(i)) begin
                tests_failed++;
                $display("FAIL b2b_drain_%0d got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, 8'h52 + 8'(i));
            end
            @(negedge clk);
        end
        #1;
        tests_run++;
        if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_empty got %b exp 0", tx_valid); end
        tx_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_drain();
        logic [31:0] d;
        tx_ready = 1'b0;
        write_word(A_LED, 32'h0000_ABCD);
        for (int i = 0; i < 3; i++) write_word(A_TXDATA, 32'h0000_0061 + 32'(i));
        tx_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (tx_data !== 8'h62) begin tests_failed++; $display("FAIL mid_drain_head got %h exp 62", tx_data); end
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL async_rst_valid got %b exp 0", tx_valid); end
        tests_run++;
        if (led !== 16'h0) begin tests_failed++; $display("FAIL async_rst_led got %h exp 0", led); end
        tests_run++;
        if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL async_rst_txdata got %h exp 00", tx_data); end
        read_word(A_STATUS, d);
        tests_run++;
        if (d !== 32'h0000_0002) begin tests_failed++; $display("FAIL async_rst_status got %h exp 00000002", d); end
        tx_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        write_word(A_TXDATA, 32'h0000_0070);
        read_word(A_STATUS, d);
        tests_run++;
        if (d !== 32'h0000_0100 || tx_data !== 8'h70) begin
            tests_failed++;
            $display("FAIL post_rst_push got st=%h d=%h exp st=00000100 d=70", d, tx_data);
        end
        @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        addr         = 32'h0;
        write_data   = 32'h0;
        tx_ready     = 1'b0;
        rst          = 1'b1;
        #1;
        rst          = 1'b0;
        #1;
        test_reset();
        test_ram();
        test_led();
        test_cycle();
        test_fifo_overflow();
        test_back_to_back();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
